vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Generates the 1280x1024@60 Hz raster for the display path.
- Drives the pixel coordinates X/Y into the RAM-to-colour stage.
- Drives the sync and blanking signals, re-aligned to that stage's RAM read latency.
- Emits a one-cycle frame pulse at the start of vertical blank so the life engine can update/swap the cell RAM outside the visible area.

Parameters:
- H_VISIBLE, 1280, visible pixels per line
- H_FRONT, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width
- H_BACK, 248, horizontal back porch
- V_VISIBLE, 1024, visible lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width
- V_BACK, 38, vertical back porch
- SYNC_POL, 1, sync active level (1 = active-high)
- PIPE_DLY, 1, clocks by which hsync/vsync/active lag X/Y (0..4)

Ports:
- clk  in  1  pixel clock, 108 MHz
- rst_n  in  1  asynchronous active-low reset
- X  out  11  horizontal counter, 0..H_TOTAL-1
- Y  out  11  vertical counter, 0..V_TOTAL-1
- active  out  1  visible-area flag, delayed PIPE_DLY
- hsync  out  1  horizontal sync, delayed PIPE_DLY
- vsync  out  1  vertical sync, delayed PIPE_DLY
- frame_pulse  out  1  one-cycle pulse at start of vertical blank (undelayed)

Behaviour:
- Derived constants: H_TOTAL = sum of H_* = 1688; V_TOTAL = sum of V_* = 1066. Both fit 11 bits; the width rule is that X/Y never exceed 2047.
- One clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered.
- Reset values:
  - X = 0, Y = 0.
  - active = 0, frame_pulse = 0.
  - hsync and vsync at their inactive level (= !SYNC_POL).
  - Every delay-line stage is cleared to these inactive values.
- Counters:
  - X increments every clk.
  - At X == H_TOTAL-1: X wraps to 0 and Y increments.
  - At X == H_TOTAL-1 and Y == V_TOTAL-1: both wrap to 0 in the same cycle.
- Raw decode, combinational from the current X/Y:
  - act_r = (X < H_VISIBLE) && (Y < V_VISIBLE).
  - hs_r = SYNC_POL when H_VISIBLE+H_FRONT <= X < H_VISIBLE+H_FRONT+H_SYNC, i.e. 1328..1439; otherwise !SYNC_POL.
  - vs_r = SYNC_POL when V_VISIBLE+V_FRONT <= Y < V_VISIBLE+V_FRONT+V_SYNC, i.e. 1025..1027; otherwise !SYNC_POL.
  - vsync changes at X == 0 of the line.
- Delay:
  - act_r, hs_r and vs_r pass through a PIPE_DLY-stage register chain. PIPE_DLY = 0 means direct combinational decode of the registered counters.
  - The outputs then correspond to the X/Y presented PIPE_DLY clocks earlier. This matches the synchronous cell-RAM read, so colour, sync and active arrive together.
- frame_pulse:
  - High for exactly one clk in the cycle where X == 0 and Y == V_VISIBLE.
  - Not delayed.
  - Never asserted during reset or in the first frame before Y reaches V_VISIBLE.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). After release, counting restarts at X = 0, Y = 0. The delay chain emits inactive values until it refills.
- Line/frame boundary: at the wrap X = 1687 -> 0, active must not glitch high for a blank-area pixel.

Decomposition:
- Package vga_pkg:
  - timing defaults (H_*, V_*, and the derived H_TOTAL/V_TOTAL, HS_START/HS_END, VS_START/VS_END);
  - the coordinate width constant COORD_W = 11, so the downstream stage and the life engine share the same values.
- Sub-module sig_delay: parameterised width and depth (depth 0 = wire), asynchronous active-low clear to a parameterised reset value. Instantiate it once, with width 3, for {active, hsync, vsync}.

Test Plan:
- Reset released at t0 -> X = 0, Y = 0, hsync = vsync = 0, active = 0; with PIPE_DLY = 1, active = 1 first at the cycle after X = 0 is presented.
- Free-run one line -> X counts 0..1687 then 0 and Y goes 0 -> 1; hsync high for exactly 112 clocks, first while X = 1329 (PIPE_DLY = 1); active high for exactly 1280 clocks per visible line.
- Free-run a full frame -> 1688*1066 = 1,799,408 clocks between consecutive frame_pulses; frame_pulse seen at X = 0, Y = 1024 only; vsync high for 3 lines (3*1688 = 5064 clocks) starting one clock after Y = 1025, X = 0.
- Line 1023 -> 1024 transition -> active stays 0 through the whole of line 1024 and all of vertical blank; at Y = 0, X = 0 of the next frame, active returns 1 after PIPE_DLY.
- Assert rst_n = 0 at X = 700, Y = 500 -> all outputs go to reset values within the same cycle (asynchronous); after release, counting resumes at 0,0 with no spurious frame_pulse.
- Re-run with PIPE_DLY = 0 and SYNC_POL = 0 -> hsync low for X = 1328..1439 in the same cycle as the counter; idle level 1 after reset.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 1280x1024@60 raster timing constants
//
// Timing defaults for the display path. The RAM-to-colour stage and the
// life engine import COORD_W from here so all blocks agree on coordinate size.
package vga_pkg;

    localparam int COORD_W   = 11;

    localparam int H_VISIBLE = 1280;
    localparam int H_FRONT   = 48;
    localparam int H_SYNC    = 112;
    localparam int H_BACK    = 248;

    localparam int V_VISIBLE = 1024;
    localparam int V_FRONT   = 1;
    localparam int V_SYNC    = 3;
    localparam int V_BACK    = 38;

    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;   // 1688
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;   // 1066

    localparam int HS_START  = H_VISIBLE + H_FRONT;                     // 1328
    localparam int HS_END    = HS_START + H_SYNC;                       // 1440, exclusive
    localparam int VS_START  = V_VISIBLE + V_FRONT;                     // 1025
    localparam int VS_END    = VS_START + V_SYNC;                       // 1028, exclusive

endpackage

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster output bundle from vga_timing to the colour stage
//
// master (vga_timing): drives X, Y, active, hsync, vsync, frame_pulse
// slave  (consumers):  samples the same signals
interface vga_timing_if;
    import vga_pkg::*;

    logic [COORD_W-1:0] X;
    logic [COORD_W-1:0] Y;
    logic               active;
    logic               hsync;
    logic               vsync;
    logic               frame_pulse;

    modport master (output X, Y, active, hsync, vsync, frame_pulse);
    modport slave  (input  X, Y, active, hsync, vsync, frame_pulse);

endinterface

// File: rtl/vga_timing_sig_delay.sv
// rtl/vga_timing_sig_delay.sv - fixed-depth register chain with async clear
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low clear, every stage loads RST_VAL
//   d      in   WIDTH-bit input
//   q      out  d delayed by DEPTH clocks (DEPTH = 0 is a wire)
module sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Even with no storage the output must show the reset value while
            // rst_n is low, otherwise a pass-through would leak decoded values.
            assign q = rst_n ? d : RST_VAL;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RST_VAL;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 1280x1024@60 raster counter, sync/blank decode, frame pulse
//
// Ports:
//   clk    in   108 MHz pixel clock
//   rst_n  in   asynchronous active-low reset
//   vga    master modport of vga_timing_if:
//            X, Y         raster counters (undelayed)
//            active       visible-area flag, PIPE_DLY clocks behind X/Y
//            hsync/vsync  syncs at SYNC_POL, PIPE_DLY clocks behind X/Y
//            frame_pulse  one clock at X = 0, Y = V_VISIBLE (undelayed)
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK,
    parameter bit SYNC_POL  = 1'b1,
    parameter int PIPE_DLY  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master vga
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS_C  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_BEG_C = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END_C = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG_C = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END_C = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    // Delay-line clear value: blank, both syncs idle.
    localparam logic [2:0] DLY_RST = {1'b0, ~SYNC_POL, ~SYNC_POL};

    logic [COORD_W-1:0] x_q, y_q;
    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic               fp_q;
    logic               act_r, hs_r, vs_r;
    logic [2:0]         dly_q;

    always_comb begin
        x_nxt = x_q + COORD_W'(1);
        y_nxt = y_q;
        if (x_q == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
        end
    end

    // frame_pulse is decoded from the next counter value so it is registered
    // yet lines up with the cycle in which X = 0, Y = V_VISIBLE is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            fp_q <= 1'b0;
        end else begin
            x_q  <= x_nxt;
            y_q  <= y_nxt;
            fp_q <= (x_nxt == '0) && (y_nxt == V_VIS_C);
        end
    end

    // vsync depends only on Y, so it naturally changes at X = 0.
    always_comb begin
        act_r = (x_q < H_VIS_C) && (y_q < V_VIS_C);
        hs_r  = ((x_q >= HS_BEG_C) && (x_q < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
        vs_r  = ((y_q >= VS_BEG_C) && (y_q < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
    end

    // Matches the synchronous cell-RAM read so colour and sync arrive together.
    sig_delay #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (DLY_RST)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({act_r, hs_r, vs_r}),
        .q     (dly_q)
    );

    assign vga.X           = x_q;
    assign vga.Y           = y_q;
    assign vga.active      = dly_q[2];
    assign vga.hsync       = dly_q[1];
    assign vga.vsync       = dly_q[0];
    assign vga.frame_pulse = fp_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed bench for vga_timing
module tb_vga_timing;

    localparam int HT  = 1688;
    localparam int VT1 = 10;            // short-frame instance: 4 visible + 1 + 3 + 2
    localparam int FR1 = HT * VT1;      // 16880 clocks per short frame

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vga_timing_if v0 ();
    vga_timing_if v1 ();
    vga_timing_if v2 ();

    // Full 1280x1024 timing, PIPE_DLY 1, active-high syncs.
    vga_timing #(.SYNC_POL(1'b1), .PIPE_DLY(1)) u0 (.clk(clk), .rst_n(rst_n), .vga(v0));

    // Short frame so whole-frame behaviour fits in a short run.
    vga_timing #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(3), .V_BACK(2),
                 .SYNC_POL(1'b1), .PIPE_DLY(1)) u1 (.clk(clk), .rst_n(rst_n), .vga(v1));

    // Zero delay, active-low syncs.
    vga_timing #(.SYNC_POL(1'b0), .PIPE_DLY(0)) u2 (.clk(clk), .rst_n(rst_n), .vga(v2));

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    int k;
    int phase;
    int xerr;
    int hs0_cnt, hs0_first, act0_cnt;
    int hs2_cnt, hs2_first, act2_cnt;
    int vs1_cnt, vs1_first, act1_cnt;
    int fp0_cnt, fp1_cnt, fp1_first, fp1_second;

    task automatic check_reset_vals(input string tag);
        check({tag, "_x0"},  v0.X, 0);
        check({tag, "_y0"},  v0.Y, 0);
        check({tag, "_act0"}, v0.active, 0);
        check({tag, "_hs0"}, v0.hsync, 0);
        check({tag, "_vs0"}, v0.vsync, 0);
        check({tag, "_fp0"}, v0.frame_pulse, 0);
        check({tag, "_x1"},  v1.X, 0);
        check({tag, "_y1"},  v1.Y, 0);
        check({tag, "_act1"}, v1.active, 0);
        check({tag, "_fp1"}, v1.frame_pulse, 0);
        check({tag, "_act2"}, v2.active, 0);
        check({tag, "_hs2"}, v2.hsync, 1);
        check({tag, "_vs2"}, v2.vsync, 1);
    endtask

    // One clock: advance, then sample on the falling edge. k counts clocks
    // since reset release, so every instance is expected at X = k mod 1688.
    task automatic step();
        int ex, ey0, ey1;
        @(posedge clk);
        k++;
        @(negedge clk);
        ex  = k % HT;
        ey0 = (k / HT) % 1066;
        ey1 = (k / HT) % VT1;
        if (v0.X != ex || v0.Y != ey0) xerr++;
        if (v1.X != ex || v1.Y != ey1) xerr++;
        if (v2.X != ex || v2.Y != ey0) xerr++;
        if (v0.frame_pulse) fp0_cnt++;
        if (v1.frame_pulse) begin
            fp1_cnt++;
            check("fp1_x", v1.X, 0);
            check("fp1_y", v1.Y, 4);
            if (fp1_cnt == 1) fp1_first = k;
            if (fp1_cnt == 2) fp1_second = k;
        end
        if (phase == 1) begin
            if (k <= HT) begin
                if (v0.hsync) begin
                    if (hs0_cnt == 0) hs0_first = v0.X;
                    hs0_cnt++;
                end
                if (v0.active) act0_cnt++;
                if (!v2.hsync) begin
                    if (hs2_cnt == 0) hs2_first = v2.X;
                    hs2_cnt++;
                end
                if (v2.active) act2_cnt++;
            end
            if (k <= FR1) begin
                if (v1.vsync) begin
                    if (vs1_cnt == 0) vs1_first = k;
                    vs1_cnt++;
                end
                if (v1.active) act1_cnt++;
            end
            if (k == 1)          check("act0_first_after_x0", v0.active, 1);
            if (k == HT - 1)     check("x0_line_end", v0.X, HT - 1);
            if (k == HT)         check("y0_after_wrap", v0.Y, 1);
            if (k == HT)         check("x0_after_wrap", v0.X, 0);
            if (k == 4 * HT + 1) check("act1_line4_start", v1.active, 0);
            if (k == FR1)        check("act1_at_frame_wrap", v1.active, 0);
            if (k == FR1)        check("y1_frame_wrap", v1.Y, 0);
            if (k == FR1 + 1)    check("act1_new_frame", v1.active, 1);
        end
    endtask

    initial begin
        bit reached;
        k = 0; phase = 0; xerr = 0;
        hs0_cnt = 0; hs0_first = -1; act0_cnt = 0;
        hs2_cnt = 0; hs2_first = -1; act2_cnt = 0;
        vs1_cnt = 0; vs1_first = -1; act1_cnt = 0;
        fp0_cnt = 0; fp1_cnt = 0; fp1_first = -1; fp1_second = -1;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        rst_n = 1'b1;
        #1;
        check("x0_release", v0.X, 0);
        check("act0_release", v0.active, 0);

        phase = 1;
        for (int i = 0; i < 4 * HT + FR1 + 100; i++) step();

        check("hs0_count", hs0_cnt, 112);
        check("hs0_first_x", hs0_first, 1329);
        check("act0_count", act0_cnt, 1280);
        check("hs2_low_count", hs2_cnt, 112);
        check("hs2_first_x", hs2_first, 1328);
        check("act2_count", act2_cnt, 1280);
        check("vs1_count", vs1_cnt, 3 * HT);
        check("vs1_first_k", vs1_first, 5 * HT + 1);
        check("act1_frame_count", act1_cnt, 4 * 1280);
        check("fp1_first_k", fp1_first, 4 * HT);
        check("fp1_interval", fp1_second - fp1_first, FR1);
        check("fp1_count", fp1_cnt, 2);
        check("fp0_count", fp0_cnt, 0);
        check("xy_track", xerr, 0);

        // Walk the short-frame instance to X = 700, Y = 2 and reset mid-frame.
        phase = 2;
        reached = 1'b0;
        for (int i = 0; i < FR1 + 10 && !reached; i++) begin
            step();
            if ((k % FR1) == 2 * HT + 700) reached = 1'b1;
        end
        check("mid_reset_reached", reached, 1);
        check("x1_pre_reset", v1.X, 700);
        check("y1_pre_reset", v1.Y, 2);
        check("act1_pre_reset", v1.active, 1);

        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(negedge clk);
        check("act1_held", v1.active, 0);

        rst_n = 1'b1;
        k = 0;
        xerr = 0;
        fp1_cnt = 0;
        fp0_cnt = 0;
        #1;
        check("x1_restart", v1.X, 0);
        check("y1_restart", v1.Y, 0);
        for (int i = 0; i < 6000; i++) step();
        check("fp1_after_reset", fp1_cnt, 0);
        check("xy_track_restart", xerr, 0);
        check("act1_after_restart", v1.active, (k % HT) >= 1 && (k % HT) <= 1280);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
